writeback_queue_escalar: RTL and testbench
==========================================

Name: writeback_queue_escalar

Overview:
Write-side front end for the scalar register file. Accepts scalar writeback requests from the ALU and memory-load paths over valid/ready handshakes, buffers them in a small in-order FIFO and drives the register file write port (we3/a3/wd3) one write per cycle. Also gives decode per-register pending-write status for two read addresses, so it can hold an instruction whose operand has not landed yet.

Parameters:
REGISTERS, 16, number of scalar registers; address width AW = $clog2(REGISTERS)
WIDTH, 16, data width of each register
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
alu_valid  in  1  ALU writeback request
alu_addr  in  AW  ALU destination register
alu_data  in  WIDTH  ALU result
alu_ready  out  1  ALU request accepted this cycle
mem_valid  in  1  load writeback request
mem_addr  in  AW  load destination register
mem_data  in  WIDTH  load data
mem_ready  out  1  load request accepted this cycle
wb_stall  in  1  write port unavailable this cycle; hold head entry
we3  out  1  register file write enable
a3  out  AW  register file write address
wd3  out  WIDTH  register file write data
chk_addr1  in  AW  decode operand address 1
chk_addr2  in  AW  decode operand address 2
busy1  out  1  chk_addr1 has a queued write
busy2  out  1  chk_addr2 has a queued write
count  out  $clog2(DEPTH+1)  entries held, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- State: DEPTH x {addr, data} storage, rd_ptr and wr_ptr (log2(DEPTH) bits, wrap modulo DEPTH) and count. No other outputs are registered.
- Reset (rst_n low at rising edge): rd_ptr = wr_ptr = 0, count = 0. Storage contents are don't-care.
- Values in the cycle after reset: we3 = 0, a3 = 0, wd3 = 0, busy1 = busy2 = 0, empty = 1, full = 0, count = 0.
- Reset mid-operation discards all queued writes. No write reaches the register file after the reset edge.
- Arbitration: at most one enqueue per cycle. Memory has fixed priority.
- mem_ready = !full.
- alu_ready = !full && !mem_valid. This is combinational. Ready does not depend on a pop in the same cycle, so there is no bypass when full.
- Push: the accepted {addr, data} is written at wr_ptr, and wr_ptr increments at the edge.
- Write port: we3 = !empty && !wb_stall. a3 and wd3 are the head entry when !empty, and 0 when empty, regardless of stall.
- Pop: occurs when we3 = 1 and takes effect at the same edge the register file samples the write.
- Latency: a request accepted at edge k appears on we3/a3/wd3 in the cycle after k, if the queue was empty and there is no stall. The register file holds the value after edge k+1.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Full: both readies are 0; the request is held by the source.
- Empty: we3 = 0; wb_stall has no effect.
- Ordering: strict FIFO. Two writes to the same register land in acceptance order, so the later data wins.
- Register 0 is not special; writes to it pass through.
- busy1 is combinational: OR over the valid entries (the count entries from rd_ptr) of (addr == chk_addr1). busy2 is the same for chk_addr2.
- An entry being popped this cycle still reports busy. A request being pushed this cycle does not report busy until the next cycle.
- count saturates by construction and never exceeds DEPTH, never underflows.

Test Plan:
1. Release reset, idle -> we3 = 0, empty = 1, count = 0, busy1 = busy2 = 0.
2. ALU writes 16'hABCD to reg 5, no stall -> the next cycle shows we3 = 1, a3 = 5, wd3 = ABCD; with chk_addr1 = 5, busy1 = 1 in that cycle and 0 afterwards; a register file model reads ABCD at reg 5.
3. Hold wb_stall = 1 and issue four ALU writes (reg 1 = 1111, reg 2 = 2222, reg 3 = 3333, reg 5 = 5555) -> full = 1, count = 4, alu_ready = 0, and a fifth request is held. Release the stall -> writes drain in order 1, 2, 3, 5 on consecutive cycles, then the held fifth request drains.
4. Assert mem_valid (reg 7, BEEF) and alu_valid (reg 8, CAFE) in the same cycle -> mem_ready = 1, alu_ready = 0. BEEF to reg 7 is written first, then CAFE to reg 8 once the ALU holds its request.
5. Two writes to reg 1 (0001, then 0002) -> both appear on the port in that order; the register file ends with reg 1 = 0002; busy1 (chk_addr1 = 1) stays 1 until the second pops.
6. With three entries queued and wb_stall = 1, pulse rst_n low for one edge -> count = 0, we3 = 0 after that edge, and no queued data ever appears on a3/wd3.

Source files
------------

// File: rtl/writeback_queue_escalar.sv
// Scalar register-file write front end: arbitrates ALU/load writebacks into an
// in-order FIFO, drains one write per cycle and reports per-register pending writes.
module writeback_queue_escalar #(
    parameter int REGISTERS = 16,
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 4,
    localparam int AW       = $clog2(REGISTERS),
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid,
    input  logic [AW-1:0]    alu_addr,
    input  logic [WIDTH-1:0] alu_data,
    output logic             alu_ready,
    input  logic             mem_valid,
    input  logic [AW-1:0]    mem_addr,
    input  logic [WIDTH-1:0] mem_data,
    output logic             mem_ready,
    input  logic             wb_stall,
    output logic             we3,
    output logic [AW-1:0]    a3,
    output logic [WIDTH-1:0] wd3,
    input  logic [AW-1:0]    chk_addr1,
    input  logic [AW-1:0]    chk_addr2,
    output logic             busy1,
    output logic             busy2,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0]    addr_mem [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    logic             push;
    logic             pop;
    logic [AW-1:0]    push_addr;
    logic [WIDTH-1:0] push_data;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign mem_ready = !full;
    // Ready ignores a same-cycle pop: a full queue never accepts, even while draining.
    assign alu_ready = !full && !mem_valid;

    assign push      = (mem_valid || alu_valid) && !full;
    assign push_addr = mem_valid ? mem_addr : alu_addr;
    assign push_data = mem_valid ? mem_data : alu_data;

    assign we3 = !empty && !wb_stall;
    assign pop = we3;
    assign a3  = empty ? '0 : addr_mem[rd_ptr];
    assign wd3 = empty ? '0 : data_mem[rd_ptr];

    // NOTE: storage has no reset; occupancy comes solely from count, so stale
    // entries are never observed and the array can map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: outputs get defaults before the loop so no path leaves them unassigned.
    always_comb begin
        logic [PW-1:0] idx;
        busy1 = 1'b0;
        busy2 = 1'b0;
        idx   = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count) begin
                if (addr_mem[idx] == chk_addr1) busy1 = 1'b1;
                if (addr_mem[idx] == chk_addr2) busy2 = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_writeback_queue_escalar.sv
// Directed bench for writeback_queue_escalar: arbitration, ordering, stall,
// pending-write status and mid-operation reset against hand-computed values.
module tb_writeback_queue_escalar;

    localparam int AW = 4;
    localparam int W  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid, mem_valid, wb_stall;
    logic [AW-1:0] alu_addr, mem_addr, chk_addr1, chk_addr2;
    logic [W-1:0]  alu_data, mem_data;
    logic          alu_ready, mem_ready, we3, busy1, busy2, full, empty;
    logic [AW-1:0] a3;
    logic [W-1:0]  wd3;
    logic [2:0]    count;

    writeback_queue_escalar dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .wb_stall(wb_stall), .we3(we3), .a3(a3), .wd3(wd3),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .busy1(busy1), .busy2(busy2),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        int            cyc;
    } wr_t;

    wr_t          log_q[$];
    logic [W-1:0] rf [16];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_pass = 0;

    // Register-file model plus a log of every write the port performs.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (we3) begin
            rf[a3] = wd3;
            log_q.push_back('{addr: a3, data: wd3, cyc: cyc});
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_push(input logic [AW-1:0] a, input logic [W-1:0] d);
        alu_valid = 1'b1; alu_addr = a; alu_data = d;
        #1;
        check($sformatf("alu_ready_push_r%0d", a), alu_ready, 1'b1);
        tick();
        alu_valid = 1'b0;
    endtask

    task automatic wait_empty(input string tag, input int budget);
        for (int i = 0; i < budget && !empty; i++) tick();
        check(tag, empty, 1'b1);
    endtask

    task automatic check_log(input string tag, input logic [AW-1:0] a[], input logic [W-1:0] d[]);
        check({tag, "_len"}, log_q.size(), a.size());
        for (int i = 0; i < a.size() && i < log_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), log_q[i].addr, a[i]);
            check($sformatf("%s_data%0d", tag, i), log_q[i].data, d[i]);
            if (i > 0) check($sformatf("%s_gap%0d", tag, i), log_q[i].cyc - log_q[i-1].cyc, 1);
        end
    endtask

    initial begin
        logic [AW-1:0] ea[];
        logic [W-1:0]  ed[];
        for (int i = 0; i < 16; i++) rf[i] = '0;
        rst_n = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0; wb_stall = 1'b0;
        alu_addr = '0; alu_data = '0; mem_addr = '0; mem_data = '0;
        chk_addr1 = '0; chk_addr2 = '0;
        tick(); tick();
        rst_n = 1'b1;
        #1;

        // 1: idle after reset
        check("rst_we3", we3, 1'b0);
        check("rst_a3", a3, 4'd0);
        check("rst_wd3", wd3, 16'd0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_count", count, 3'd0);
        check("rst_busy1", busy1, 1'b0);
        check("rst_busy2", busy2, 1'b0);

        // 2: single ALU write, one-cycle latency, busy during its drain cycle
        chk_addr1 = 4'd5; chk_addr2 = 4'd6;
        alu_valid = 1'b1; alu_addr = 4'd5; alu_data = 16'hABCD;
        #1;
        check("t2_busy_on_push", busy1, 1'b0);
        tick();
        alu_valid = 1'b0;
        #1;
        check("t2_we3", we3, 1'b1);
        check("t2_a3", a3, 4'd5);
        check("t2_wd3", wd3, 16'hABCD);
        check("t2_busy1", busy1, 1'b1);
        check("t2_busy2", busy2, 1'b0);
        check("t2_count", count, 3'd1);
        tick();
        check("t2_busy1_after", busy1, 1'b0);
        check("t2_empty", empty, 1'b1);
        check("t2_rf5", rf[5], 16'hABCD);

        // 3: fill under stall, held fifth request, ordered drain
        log_q.delete();
        wb_stall = 1'b1;
        alu_push(4'd1, 16'h1111);
        alu_push(4'd2, 16'h2222);
        alu_push(4'd3, 16'h3333);
        alu_push(4'd5, 16'h5555);
        alu_valid = 1'b1; alu_addr = 4'd6; alu_data = 16'h6666;
        #1;
        check("t3_full", full, 1'b1);
        check("t3_count", count, 3'd4);
        check("t3_alu_ready", alu_ready, 1'b0);
        check("t3_mem_ready", mem_ready, 1'b0);
        check("t3_we3_stalled", we3, 1'b0);
        check("t3_a3_stalled", a3, 4'd1);
        check("t3_wd3_stalled", wd3, 16'h1111);
        check("t3_busy1_r5", busy1, 1'b1);
        check("t3_busy2_r6", busy2, 1'b0);
        tick();
        check("t3_count_held", count, 3'd4);
        wb_stall = 1'b0;
        #1;
        check("t3_no_bypass", alu_ready, 1'b0);
        check("t3_we3_release", we3, 1'b1);
        tick();
        check("t3_ready_after_pop", alu_ready, 1'b1);
        tick();
        alu_valid = 1'b0;
        check("t3_count_pushpop", count, 3'd3);
        wait_empty("t3_drain", 20);
        ea = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd6};
        ed = '{16'h1111, 16'h2222, 16'h3333, 16'h5555, 16'h6666};
        check_log("t3_log", ea, ed);

        // 4: memory has priority over ALU
        log_q.delete();
        mem_valid = 1'b1; mem_addr = 4'd7; mem_data = 16'hBEEF;
        alu_valid = 1'b1; alu_addr = 4'd8; alu_data = 16'hCAFE;
        #1;
        check("t4_mem_ready", mem_ready, 1'b1);
        check("t4_alu_ready", alu_ready, 1'b0);
        tick();
        mem_valid = 1'b0;
        #1;
        check("t4_alu_ready_next", alu_ready, 1'b1);
        tick();
        alu_valid = 1'b0;
        wait_empty("t4_drain", 20);
        ea = '{4'd7, 4'd8};
        ed = '{16'hBEEF, 16'hCAFE};
        check_log("t4_log", ea, ed);
        check("t4_rf7", rf[7], 16'hBEEF);
        check("t4_rf8", rf[8], 16'hCAFE);

        // 5: same-register writes land in order, busy until the last pops
        chk_addr1 = 4'd1; chk_addr2 = 4'd0;
        wb_stall = 1'b1;
        alu_push(4'd1, 16'h0001);
        alu_push(4'd1, 16'h0002);
        wb_stall = 1'b0;
        #1;
        check("t5_busy_a", busy1, 1'b1);
        check("t5_wd3_a", wd3, 16'h0001);
        tick();
        check("t5_busy_b", busy1, 1'b1);
        check("t5_wd3_b", wd3, 16'h0002);
        tick();
        check("t5_busy_c", busy1, 1'b0);
        check("t5_rf1", rf[1], 16'h0002);

        // 6: reset mid-operation discards queued writes
        wb_stall = 1'b1;
        alu_push(4'd9, 16'h9999);
        alu_push(4'd10, 16'hAAAA);
        alu_push(4'd11, 16'hBBBB);
        check("t6_count_pre", count, 3'd3);
        log_q.delete();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_count", count, 3'd0);
        check("t6_we3", we3, 1'b0);
        check("t6_a3", a3, 4'd0);
        check("t6_wd3", wd3, 16'd0);
        wb_stall = 1'b0;
        repeat (5) tick();
        check("t6_no_writes", log_q.size(), 0);
        check("t6_rf9", rf[9], 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
